// File: rtl/ysyx_040066_clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled mtime, per-hart mtimecmp
// and msip, decoded from a 48 KiB window on the LSU path; misses pass through.
module ysyx_040066_clint_mh #(
  parameter int unsigned NHART    = 2,
  parameter logic [63:0] BASE     = 64'h2000000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      addr,
  input  logic             MemRd,
  input  logic             MemWr,
  input  logic [63:0]      data,
  input  logic [7:0]       wmask,
  output logic             MemRd_real,
  output logic             MemWr_real,
  output logic [63:0]      data_rd,
  output logic             rd_valid,
  output logic             error,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [63:0] WIN_END  = BASE + 64'hC000;
  localparam logic [15:0] BASE_LO  = BASE[15:0];

  logic [63:0] mtime;
  logic [63:0] mtimecmp [NHART];
  logic [PW-1:0] pcnt;

  // ---------------------------------------------------------------------------
  // Window decode. The offset is below 0xC000 whenever hit is set, so 16-bit
  // modular subtraction yields the exact offset.
  // ---------------------------------------------------------------------------
  logic        hit;
  logic [15:0] off;
  logic [11:0] msip_idx;
  logic [12:0] cmp_idx;
  logic        in_msip, in_time, in_cmp;
  logic        ok_msip, ok_cmp, ok_time, legal, bad;

  assign hit      = (addr >= BASE) && (addr < WIN_END);
  assign off      = addr[15:0] - BASE_LO;
  assign msip_idx = off[13:2];
  assign cmp_idx  = off[15:3] - 13'h0800;

  assign in_msip  = off < 16'h4000;
  assign in_time  = off[15:3] == 13'h17FF;
  assign in_cmp   = !in_msip && !in_time;

  assign ok_msip  = hit && in_msip && (off[1:0] == 2'b00) && (msip_idx < 12'(NHART));
  assign ok_cmp   = hit && in_cmp  && (off[2:0] == 3'b000) && (cmp_idx < 13'(NHART));
  assign ok_time  = hit && in_time && (off[2:0] == 3'b000);
  assign legal    = ok_msip || ok_cmp || ok_time;
  assign bad      = hit && (MemRd || MemWr) && !legal;

  assign MemRd_real = MemRd && !hit;
  assign MemWr_real = MemWr && !hit;

  // ---------------------------------------------------------------------------
  // Byte-lane mask and read mux (old register values, before any write/tick).
  // ---------------------------------------------------------------------------
  logic [63:0] bmask;
  logic [63:0] rdata;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) bmask[8*i +: 8] = {8{wmask[i]}};
  end

  always_comb begin
    rdata = '0;
    for (int h = 0; h < NHART; h++) begin
      if (ok_msip && msip_idx[2:0] == 3'(h))
        rdata = off[2] ? {31'b0, msip[h], 32'b0} : {63'b0, msip[h]};
      if (ok_cmp && cmp_idx[2:0] == 3'(h))
        rdata = mtimecmp[h];
    end
    if (ok_time) rdata = mtime;
  end

  // ---------------------------------------------------------------------------
  // Prescaler and timer compare.
  // ---------------------------------------------------------------------------
  logic        tick;
  logic        wr_time;
  logic [63:0] mtime_inc;

  assign tick      = (pcnt == PCNT_MAX);
  assign wr_time   = MemWr && ok_time;
  assign mtime_inc = tick ? mtime + 64'd1 : mtime;

  always_comb begin
    mtip = '0;
    for (int h = 0; h < NHART; h++) mtip[h] = (mtime >= mtimecmp[h]);
  end

  // ---------------------------------------------------------------------------
  // State update.
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, which is what the read-old-value and
  // write-beats-tick ordering relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      pcnt     <= '0;
      msip     <= '0;
      data_rd  <= '0;
      rd_valid <= 1'b0;
      error    <= 1'b0;
      // NOTE: mtimecmp is a handful of flops, not a RAM macro, so it is reset
      // like any other register; all-ones keeps mtip low out of reset.
      for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
    end else begin
      if (wr_time) begin
        mtime <= (mtime_inc & ~bmask) | (data & bmask);
        pcnt  <= '0;
      end else begin
        mtime <= mtime_inc;
        pcnt  <= tick ? '0 : pcnt + PW'(1);
      end

      for (int h = 0; h < NHART; h++) begin
        if (MemWr && ok_cmp && cmp_idx[2:0] == 3'(h))
          mtimecmp[h] <= (mtimecmp[h] & ~bmask) | (data & bmask);
        if (MemWr && ok_msip && msip_idx[2:0] == 3'(h) && (off[2] ? wmask[4] : wmask[0]))
          msip[h] <= off[2] ? data[32] : data[0];
      end

      rd_valid <= MemRd && hit;
      error    <= bad;
      if (MemRd && hit) data_rd <= rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_040066_clint_mh.sv
// Directed bench for the multi-hart CLINT: a register-map vector table plus
// timing sequences on a TICK_DIV=1 and a TICK_DIV=4 instance sharing inputs.
module tb_ysyx_040066_clint_mh;

  localparam logic [63:0] B    = 64'h2000000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [63:0] addr;
  logic        mem_rd, mem_wr;
  logic [63:0] wdata;
  logic [7:0]  wmask;

  logic        rd_real_1, wr_real_1, rv_1, err_1;
  logic [63:0] data_rd_1;
  logic [1:0]  mtip_1, msip_1;
  logic        rd_real_4, wr_real_4, rv_4, err_4;
  logic [63:0] data_rd_4;
  logic [1:0]  mtip_4, msip_4;

  int checks = 0;
  int errors = 0;
  int n = 0;

  ysyx_040066_clint_mh #(.NHART(2), .BASE(B), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .MemRd(mem_rd), .MemWr(mem_wr),
    .data(wdata), .wmask(wmask), .MemRd_real(rd_real_1), .MemWr_real(wr_real_1),
    .data_rd(data_rd_1), .rd_valid(rv_1), .error(err_1), .mtip(mtip_1), .msip(msip_1)
  );

  ysyx_040066_clint_mh #(.NHART(2), .BASE(B), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .MemRd(mem_rd), .MemWr(mem_wr),
    .data(wdata), .wmask(wmask), .MemRd_real(rd_real_4), .MemWr_real(wr_real_4),
    .data_rd(data_rd_4), .rd_valid(rv_4), .error(err_4), .mtip(mtip_4), .msip(msip_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: mtime model is n (div 1) and n/4 (div 4).
  always @(posedge clk) n <= rst ? 0 : n + 1;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic        ex_rd_real;
    logic        ex_wr_real;
    logic        ex_rv;
    logic        ex_err;
    logic        chk_data;
    logic [63:0] ex_data;
    logic [1:0]  ex_msip;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d; wmask = m;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [63:0] a,
                    input logic [63:0] d, input logic [7:0] m);
    drive(rd, wr, a, d, m);
    clock_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    @(posedge clk);
    #1;
    check("reset data_rd", data_rd_1, 64'd0);
    check("reset rd_valid", rv_1, 0);
    check("reset error", err_1, 0);
    check("reset mtip", mtip_1 | mtip_4, 0);
    check("reset msip", msip_1, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_n(input int target);
    int g = 0;
    while (n != target && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("wait_n cycle", n, target);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0; wmask = '0;

    //             rd wr addr              data                   mask  rr ww rv er chk data                     msip
    vecs[0]  = '{0, 1, B + 64'h4,       64'h1_0000_0000,       8'hF0, 0, 0, 0, 0, 0, 64'h0,                  2'b10};
    vecs[1]  = '{1, 0, B + 64'h4,       64'h0,                 8'h00, 0, 0, 1, 0, 1, 64'h1_0000_0000,        2'b10};
    vecs[2]  = '{1, 0, B,               64'h0,                 8'h00, 0, 0, 1, 0, 1, 64'h0,                  2'b10};
    vecs[3]  = '{0, 1, B,               64'h1,                 8'h01, 0, 0, 0, 0, 0, 64'h0,                  2'b11};
    vecs[4]  = '{0, 1, B + 64'h4,       64'h0,                 8'hF0, 0, 0, 0, 0, 0, 64'h0,                  2'b01};
    vecs[5]  = '{0, 1, B,               64'h0,                 8'hFE, 0, 0, 0, 0, 0, 64'h0,                  2'b01};
    vecs[6]  = '{0, 1, B,               64'h0,                 8'h01, 0, 0, 0, 0, 0, 64'h0,                  2'b00};
    vecs[7]  = '{0, 1, B + 64'h8,       ONES,                  8'hFF, 0, 0, 0, 1, 0, 64'h0,                  2'b00};
    vecs[8]  = '{1, 0, B + 64'h8,       64'h0,                 8'h00, 0, 0, 1, 1, 1, 64'h0,                  2'b00};
    vecs[9]  = '{1, 0, B + 64'h2,       64'h0,                 8'h00, 0, 0, 1, 1, 1, 64'h0,                  2'b00};
    vecs[10] = '{0, 1, B + 64'h4000,    64'hAB,                8'h01, 0, 0, 0, 0, 0, 64'h0,                  2'b00};
    vecs[11] = '{1, 0, B + 64'h4000,    64'h0,                 8'h00, 0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00};
    vecs[12] = '{1, 0, B + 64'h4004,    64'h0,                 8'h00, 0, 0, 1, 1, 1, 64'h0,                  2'b00};
    vecs[13] = '{0, 1, B + 64'h4010,    64'h0,                 8'hFF, 0, 0, 0, 1, 0, 64'h0,                  2'b00};
    vecs[14] = '{1, 0, B + 64'h4008,    64'h0,                 8'h00, 0, 0, 1, 0, 1, ONES,                   2'b00};
    vecs[15] = '{1, 0, 64'h8000_0000,   64'h0,                 8'h00, 1, 0, 0, 0, 1, ONES,                   2'b00};
    vecs[16] = '{0, 1, 64'h8000_0000,   64'h1,                 8'hFF, 0, 1, 0, 0, 0, 64'h0,                  2'b00};
    vecs[17] = '{1, 0, B + 64'hC000,    64'h0,                 8'h00, 1, 0, 0, 0, 0, 64'h0,                  2'b00};
    vecs[18] = '{1, 0, B - 64'h8,       64'h0,                 8'h00, 1, 0, 0, 0, 0, 64'h0,                  2'b00};
    vecs[19] = '{1, 1, B + 64'h4000,    64'h55,                8'h01, 0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00};
    vecs[20] = '{1, 0, B + 64'h4000,    64'h0,                 8'h00, 0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF55, 2'b00};
    vecs[21] = '{1, 0, B + 64'hBFFC,    64'h0,                 8'h00, 0, 0, 1, 1, 1, 64'h0,                  2'b00};
    vecs[22] = '{1, 0, B + 64'hBFF0,    64'h0,                 8'h00, 0, 0, 1, 1, 1, 64'h0,                  2'b00};
    vecs[23] = '{1, 1, 64'h8000_0000,   64'h0,                 8'hFF, 1, 1, 0, 0, 0, 64'h0,                  2'b00};

    // 1. Reset and counting: a load in cycle 10 sees mtime 10 (div 1) / 2 (div 4).
    do_reset();
    wait_n(10);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("count div1 data", data_rd_1, 64'd10);
    check("count div1 rd_valid", rv_1, 1);
    check("count div4 data", data_rd_4, 64'd2);
    check("count mtip", mtip_1, 0);

    // Register-map vector table.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].m);
      #1;
      check($sformatf("v%0d MemRd_real", i), rd_real_1, vecs[i].ex_rd_real);
      check($sformatf("v%0d MemWr_real", i), wr_real_1, vecs[i].ex_wr_real);
      clock_edge();
      check($sformatf("v%0d rd_valid", i), rv_1, vecs[i].ex_rv);
      check($sformatf("v%0d error", i), err_1, vecs[i].ex_err);
      check($sformatf("v%0d msip", i), msip_1, vecs[i].ex_msip);
      if (vecs[i].chk_data)
        check($sformatf("v%0d data_rd", i), data_rd_1, vecs[i].ex_data);
    end

    // 2. Timer compare on hart 1.
    do_reset();
    wait_n(5);
    op(0, 1, B + 64'h4008, 64'h20, 8'hFF);
    wait_n(32'h1F);
    check("mtip before cmp", mtip_1, 2'b00);
    @(posedge clk);
    #1;
    check("mtip at cmp", mtip_1, 2'b10);
    check("mtip div4 at cmp", mtip_4, 2'b00);
    op(0, 1, B + 64'h4008, 64'hFFFF, 8'hFF);
    check("mtip after rewrite", mtip_1, 2'b00);

    // 4. Prescaler and a write colliding with a tick.
    do_reset();
    wait_n(40);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("div4 mtime@40", data_rd_4, 64'd10);
    check("div4 rd_valid", rv_4, 1);
    wait_n(43);
    op(0, 1, B + 64'hBFF8, 64'h1234, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
      check($sformatf("div4 post-write load %0d", k), data_rd_4,
            (k == 4) ? 64'h1235 : 64'h1234);
    end

    // 5. Wrap and partial mtime write on the div-1 instance.
    op(0, 1, B + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("wrap load 0", data_rd_1, 64'hFFFF_FFFF_FFFF_FFFE);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("wrap load 1", data_rd_1, ONES);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("wrap load 2", data_rd_1, 64'h0);
    op(0, 1, B + 64'hBFF8, 64'h5600, 8'h02);
    op(1, 0, B + 64'hBFF8, 64'h0, 8'h00);
    check("partial mtime merge", data_rd_1, 64'h5602);

    // Reset during an in-flight load.
    op(0, 1, B, 64'h1, 8'h01);
    check("msip before rst", msip_1, 2'b01);
    @(negedge clk);
    mem_rd = 1'b1; addr = B; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst rd_valid suppressed", rv_1, 0);
    check("rst data_rd cleared", data_rd_1, 64'h0);
    check("rst msip cleared", msip_1, 2'b00);
    @(negedge clk);
    mem_rd = 1'b0; rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_clint_mh.md
# ysyx_040066_clint_mh

Multi-hart core-local interruptor that replaces the single-hart timer block on the LSU data path. It decodes a parametrised CLINT window and provides these registers:
- one shared `mtime`, advanced by a programmable prescaler;
- one `mtimecmp` per hart;
- one `msip` software-interrupt bit per hart.

Accesses outside the window are forwarded to memory unchanged. Per-hart timer and software interrupt lines go to each hart's CSR unit.

## Interface
Parameters:
- `NHART`, 2, number of harts (1..8); sizes `msip`/`mtimecmp` arrays and interrupt vectors
- `BASE`, 64'h2000000, window base; window is `BASE` .. `BASE+0xBFFF`
- `TICK_DIV`, 1, `mtime` increments once every `TICK_DIV` clk cycles (1..256)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  64  byte address of current access
- `MemRd`  in  1  load request this cycle
- `MemWr`  in  1  store request this cycle
- `data`  in  64  store data, doubleword-aligned lanes
- `wmask`  in  8  byte-enable of store, bit i = lane i
- `MemRd_real`  out  1  `MemRd` and address outside window
- `MemWr_real`  out  1  `MemWr` and address outside window
- `data_rd`  out  64  registered load data
- `rd_valid`  out  1  one-cycle pulse: `data_rd` valid for a window load issued previous cycle
- `error`  out  1  one-cycle pulse: previous-cycle window access was unmapped or misaligned
- `mtip`  out  NHART  timer interrupt per hart
- `msip`  out  NHART  software interrupt per hart

## Operation
- Window hit: `hit = addr >= BASE && addr < BASE+0xC000`. The `*_real` outputs are combinational, `Mem*_real = Mem* & ~hit`.
- Let `off = addr - BASE`. Register map:
  - `msip[h]` at `off = 4*h`, 32-bit, bit0 only; reads 0 elsewhere.
  - `mtimecmp[h]` at `0x4000 + 8*h`, 64-bit.
  - `mtime` at `0xBFF8`, 64-bit.
- Legal access:
  - `msip`: `off[1:0]==0`, `h < NHART`.
  - `mtimecmp` / `mtime`: `off[2:0]==0`, `h < NHART`.
  - Any other hit with `MemRd|MemWr` is an error. On error the write is dropped and the read returns 0.
- Writes to `mtimecmp` / `mtime` honour `wmask` per byte.
- `msip` writes use the lane selected by `addr[2]`:
  - `addr[2]==0`: enable `wmask[0]`, data bit `data[0]`.
  - `addr[2]==1`: enable `wmask[4]`, data bit `data[32]`.
- `msip` reads place the value in the same lane, upper bits 0.
- Prescaler `pcnt` (width `$clog2(TICK_DIV)`, min 1):
  - When `pcnt == TICK_DIV-1`, set `pcnt` to 0 and increment `mtime` (wraps 2^64-1 -> 0).
  - Otherwise increment `pcnt`.
  - With `TICK_DIV==1`, `mtime` increments every cycle.
- `mtip[h] = (mtime >= mtimecmp[h])`, combinational from registers (unsigned compare, ">=" not ">").
- `msip[h]` = the stored bit.
- Reset values:
  - `mtime` = 0, `pcnt` = 0.
  - all `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - all `msip` = 0.
  - `data_rd` = 0, `rd_valid` = 0, `error` = 0.
  - With these values `mtip` = 0 after reset.

## Timing
- Load latency is 1 cycle: a hit with `MemRd` in cycle N gives `data_rd` and `rd_valid=1` in N+1. `data_rd` holds its value until the next window load. Misses do not touch `data_rd` or `rd_valid`.
- A load returns the register value before any same-cycle write or tick.
- A store takes effect at the end of the cycle it is presented; the updated value is visible to a load in N+1.
- A `mtime` store in the same cycle as a tick: the written bytes win and unwritten bytes take the ticked value. `pcnt` is cleared to 0 on any `mtime` write.
- `MemRd` and `MemWr` together on a hit: the write is performed, and the read returns the old value with `rd_valid`.
- `error` is registered: a violation in cycle N pulses `error` in N+1, along with `rd_valid` if it was a load.
- `mtip` reflects new `mtime`/`mtimecmp` values in the cycle after they update. There is no interrupt-acknowledge; software clears `mtip` by rewriting `mtimecmp`.
- `rst` asserted mid-operation: all state returns to reset values on that edge, and any in-flight read's `rd_valid` is suppressed.

## Test plan
1. **Reset and counting.** `TICK_DIV=1`, release reset, wait 10 cycles, load `BASE+0xBFF8` -> `data_rd` = 10 (±1 per issue cycle), `rd_valid` pulses, `mtip==0`.
2. **Timer compare per hart.** Store 0x20 to `mtimecmp[1]` (`BASE+0x4008`, `wmask=0xFF`) at `mtime`=5 -> `mtip[1]` rises exactly in the cycle after `mtime` reaches 0x20, `mtip[0]` stays 0. Then store 0xFFFF to it -> `mtip[1]` falls next cycle.
3. **Software interrupt.** Store `data=64'h1_00000000`, `wmask=0xF0` at `BASE+4` -> `msip=2'b10`. Load `BASE+4` -> `data_rd=64'h1_00000000`. Store 0 -> `msip=0`.
4. **Prescaler and write collision.** `TICK_DIV=4`, 40 cycles -> `mtime==10`. Store `mtime=0x1234` (`wmask=0xFF`) on a tick cycle -> next load reads 0x1234 and the next increment comes 4 cycles later.
5. **Partial write and wrap.** Store 64'hFFFF_FFFF_FFFF_FFFE to `mtime` -> after 2 ticks `mtime==0`. Store `wmask=0x01`, `data=0xAB` to `mtimecmp[0]` -> reads 64'hFFFF_FFFF_FFFF_FFAB.
6. **Errors and pass-through.**
   - Load `BASE+0x4004` (misaligned) -> `error` and `rd_valid` pulse, `data_rd=0`.
   - Store `BASE+0x4000+8*NHART` -> `error`, no state change.
   - Access `0x80000000` -> `MemRd_real`/`MemWr_real` follow inputs, no `rd_valid`.
